// File: rtl/writeback.sv
// Writeback stage: buffers completed execute operations and drains them into the
// register file, one 64-bit write per cycle, and maintains RFLAGS and a retire count.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   in_valid/in_ready operation handshake from execute
//   in_result         128-bit result (low half in [63:0])
//   in_dest, in_rd_en destination GPR and its write enable
//   in_wide           upper half also writes HI_REG
//   in_flags(_en)     RFLAGS value and its update enable
//   rf_we/waddr/wdata register-file write port (address/data are zero when rf_we is 0)
//   flags_q           architectural RFLAGS
//   retired           number of drained operations (wraps at 2^64)
//   busy              buffer non-empty or drain FSM active
module writeback #(
  parameter int unsigned DEPTH  = 2,
  parameter logic [3:0]  HI_REG = 4'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_result,
  input  logic [3:0]   in_dest,
  input  logic         in_rd_en,
  input  logic         in_wide,
  input  logic [63:0]  in_flags,
  input  logic         in_flags_en,
  output logic         rf_we,
  output logic [3:0]   rf_waddr,
  output logic [63:0]  rf_wdata,
  output logic [63:0]  flags_q,
  output logic [63:0]  retired,
  output logic         busy
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StWrLo,
    StWrHi
  } state_e;

  state_e state_q;

  // Entry storage; contents need no reset since count/pointers define validity.
  logic [127:0] res_mem   [DEPTH];
  logic [3:0]   dest_mem  [DEPTH];
  logic         rd_en_mem [DEPTH];
  logic         wide_mem  [DEPTH];
  logic [63:0]  flags_mem [DEPTH];
  logic         fen_mem   [DEPTH];

  logic [AW-1:0] head_q, tail_q, head_nxt;
  logic [AW:0]   count_q;
  logic          ready_en_q;

  logic push, pop, head_wide;

  // Entry that the FSM will present in WR_LO next cycle.
  logic         sel_valid;
  logic [127:0] sel_res;
  logic [3:0]   sel_dest;
  logic         sel_rd_en;
  logic         go_lo;

  // in_ready depends only on registered state; held low through reset until the first edge.
  assign in_ready  = ready_en_q && (count_q < FULL);
  assign push      = in_valid && in_ready;
  assign head_wide = wide_mem[head_q];
  assign head_nxt  = head_q + AW'(1);
  assign pop       = ((state_q == StWrLo) && !head_wide) || (state_q == StWrHi);
  assign busy      = (count_q != '0) || (state_q != StIdle);

  // On a pop the next entry is the one behind the head, or, if the buffer is about to
  // empty, the operation being accepted this same cycle (avoids a bubble).
  always_comb begin
    sel_valid = (count_q != '0);
    sel_res   = res_mem[head_q];
    sel_dest  = dest_mem[head_q];
    sel_rd_en = rd_en_mem[head_q];
    if (pop) begin
      if (count_q > ONE) begin
        sel_valid = 1'b1;
        sel_res   = res_mem[head_nxt];
        sel_dest  = dest_mem[head_nxt];
        sel_rd_en = rd_en_mem[head_nxt];
      end else begin
        sel_valid = push;
        sel_res   = in_result;
        sel_dest  = in_dest;
        sel_rd_en = in_rd_en;
      end
    end
  end

  assign go_lo = ((state_q == StIdle) && (count_q != '0)) || (pop && sel_valid);

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[tail_q]   <= in_result;
      dest_mem[tail_q]  <= in_dest;
      rd_en_mem[tail_q] <= in_rd_en;
      wide_mem[tail_q]  <= in_wide;
      flags_mem[tail_q] <= in_flags;
      fen_mem[tail_q]   <= in_flags_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_nxt;
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Drain FSM with registered register-file outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      flags_q  <= 64'h2;
      retired  <= '0;
    end else begin
      if (pop) retired <= retired + 64'd1;

      if (state_q == StWrLo && fen_mem[head_q]) flags_q <= flags_mem[head_q];

      case (state_q)
        StWrLo: begin
          if (head_wide) begin
            state_q  <= StWrHi;
            rf_we    <= 1'b1;
            rf_waddr <= HI_REG;
            rf_wdata <= res_mem[head_q][127:64];
          end
        end
        default: ;
      endcase

      if (go_lo) begin
        state_q  <= StWrLo;
        rf_we    <= sel_rd_en;
        rf_waddr <= sel_rd_en ? sel_dest : 4'd0;
        rf_wdata <= sel_rd_en ? sel_res[63:0] : 64'd0;
      end else if (pop) begin
        state_q  <= StIdle;
        rf_we    <= 1'b0;
        rf_waddr <= '0;
        rf_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

  localparam logic [3:0] HI = 4'd2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_result = '0;
  logic [3:0]   in_dest = '0;
  logic         in_rd_en = 1'b0;
  logic         in_wide = 1'b0;
  logic [63:0]  in_flags = '0;
  logic         in_flags_en = 1'b0;
  logic         rf_we;
  logic [3:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic [63:0]  flags_q;
  logic [63:0]  retired;
  logic         busy;

  writeback #(.DEPTH(2), .HI_REG(HI)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_dest    (in_dest),
    .in_rd_en   (in_rd_en),
    .in_wide    (in_wide),
    .in_flags   (in_flags),
    .in_flags_en(in_flags_en),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .flags_q    (flags_q),
    .retired    (retired),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: ordered list of register writes, retire count, architectural flags.
  logic [67:0] exp_q[$];
  logic [63:0] model_ret = '0;
  logic [63:0] model_flags = 64'h2;
  int unsigned cyc = 0;
  int unsigned wr_cyc[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the next expected write, idle port must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) begin
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", {rf_waddr, rf_wdata}, 68'h0);
        end else begin
          check_eq("write", {rf_waddr, rf_wdata}, exp_q.pop_front());
        end
      end else begin
        check_eq("idle_port_zero", {rf_waddr, rf_wdata}, 68'h0);
      end
    end
  end

  // Starts and ends at a negedge; inputs stay valid until the accepting posedge.
  task automatic send(input logic [127:0] res, input logic [3:0] dest, input logic rd,
                      input logic wide, input logic [63:0] fl, input logic fen);
    int unsigned n;
    in_valid    = 1'b1;
    in_result   = res;
    in_dest     = dest;
    in_rd_en    = rd;
    in_wide     = wide;
    in_flags    = fl;
    in_flags_en = fen;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", 1'b0, 1'b1);
    end else begin
      @(posedge clk);
      if (rd)   exp_q.push_back({dest, res[63:0]});
      if (wide) exp_q.push_back({HI, res[127:64]});
      if (fen)  model_flags = fl;
      model_ret = model_ret + 64'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_retired"}, retired, model_ret);
    check_eq({tag, "_flags"}, flags_q, model_flags);
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_we", rf_we, 1'b0);
    check_eq("rst_waddr", rf_waddr, 4'd0);
    check_eq("rst_wdata", rf_wdata, 64'd0);
    check_eq("rst_flags", flags_q, 64'h2);
    check_eq("rst_retired", retired, 64'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("ready_before_edge", in_ready, 1'b0);
    @(posedge clk);
    #1 check_eq("ready_after_edge", in_ready, 1'b1);
    @(negedge clk);

    // Single op, 2-clock latency
    send(128'h0123_4567_0000_0000_DEAD_BEEF, 4'd3, 1'b1, 1'b0, 64'h0, 1'b0);
    check_eq("single_lat1_we", rf_we, 1'b0);
    @(negedge clk);
    check_eq("single_we", rf_we, 1'b1);
    check_eq("single_waddr", rf_waddr, 4'd3);
    check_eq("single_wdata", rf_wdata, 64'hDEAD_BEEF);
    @(negedge clk);
    check_eq("single_we_off", rf_we, 1'b0);
    check_eq("single_retired", retired, 64'd1);
    wait_idle("single");

    // Wide op
    send({64'h1111, 64'h2222}, 4'd0, 1'b1, 1'b1, 64'h0, 1'b0);
    @(negedge clk);
    check_eq("wide_lo", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd0, 64'h2222});
    @(negedge clk);
    check_eq("wide_hi", {rf_we, rf_waddr, rf_wdata}, {1'b1, HI, 64'h1111});
    wait_idle("wide");

    // Full buffer, back-to-back drain with no gaps
    wr_cyc.delete();
    send({64'hA1, 64'hA0}, 4'd4, 1'b1, 1'b1, 64'h0, 1'b0);
    send({64'hB1, 64'hB0}, 4'd5, 1'b1, 1'b0, 64'h0, 1'b0);
    check_eq("full_ready", in_ready, 1'b0);
    send({64'hC1, 64'hC0}, 4'd6, 1'b1, 1'b0, 64'h0, 1'b0);
    wait_idle("full");
    check_eq("full_nwrites", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) check_eq("full_no_gap", wr_cyc[3] - wr_cyc[0], 3);

    // Flags update then hold
    send(128'h7, 4'd1, 1'b1, 1'b0, 64'h46, 1'b1);
    send(128'h8, 4'd1, 1'b1, 1'b0, 64'h99, 1'b0);
    wait_idle("flags");
    check_eq("flags_46", flags_q, 64'h46);

    // Dest equals HI_REG on a wide op: high write comes last
    send({64'hFACE, 64'hCAFE}, HI, 1'b1, 1'b1, 64'h0, 1'b0);
    wait_idle("hi_dest");

    // Reset while in WR_HI
    send({64'h5151, 64'h5050}, 4'd7, 1'b1, 1'b1, 64'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("wrhi_seen", {rf_we, rf_waddr}, {1'b1, HI});
    #1 rst_n = 1'b0;
    #1;
    check_eq("wrhi_rst_we", rf_we, 1'b0);
    check_eq("wrhi_rst_retired", retired, 64'd0);
    check_eq("wrhi_rst_busy", busy, 1'b0);
    check_eq("wrhi_rst_ready", in_ready, 1'b0);
    exp_q.delete();
    model_ret = '0;
    model_flags = 64'h2;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(128'h1234, 4'd9, 1'b1, 1'b0, 64'h0, 1'b0);
    wait_idle("post_rst");

    // Retire counter wrap
    force dut.retired = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.retired;
    model_ret = 64'hFFFF_FFFF_FFFF_FFFF;
    send(128'h55, 4'd8, 1'b0, 1'b0, 64'h0, 1'b0);
    wait_idle("wrap");
    check_eq("wrap_zero", retired, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
